writeback_arbiter: RTL and testbench
====================================

# writeback_arbiter

Shares the single register-file write port between the two writeback sources in the pipeline: the ALU result path and the memory/load result path. Each source pushes {address, value} through a valid/ready handshake into its own FIFO. A round-robin arbiter pops at most one entry per cycle. The winner is driven, registered, onto the packed 69-bit write-back bus consumed by the register write-back unit.

## Interface
- `DEPTH`, default 4: entries per source FIFO. Must be a power of two and at least 2.
- `clk` input, 1 bit: clock. All state updates on the rising edge.
- `reset` input, 1 bit: asynchronous, active-high reset. One clock domain only.
- `alu_valid` input, 1 bit: ALU writeback request.
- `alu_ready` output, 1 bit: ALU FIFO not full.
- `alu_addr` input, 4 bits: ALU destination register.
- `alu_value` input, 64 bits: ALU result.
- `mem_valid` input, 1 bit: memory/load writeback request.
- `mem_ready` output, 1 bit: memory FIFO not full.
- `mem_addr` input, 4 bits: memory destination register.
- `mem_value` input, 64 bits: load data.
- `wb_bus` output, 69 bits: packed write-back bus, registered.
  - [3:0] address.
  - [67:4] value.
  - [68] is_write.
- `idle` output, 1 bit: both FIFOs empty and `wb_bus[68]`=0.
- `pending_mask` output, 16 bits: present only with `WB_ARB_PENDING_MASK_EN`.

## Operation
- **Push:** a push occurs when `x_valid && x_ready` at a rising edge. `x_ready` = !full.
  - A full FIFO does not accept a push, even when it is being popped in the same cycle.
- **Ordering:** within one source, FIFO order is preserved. Across sources, the order is the grant order only.
- **Arbitration state:** a one-bit `last_grant` register (0=ALU, 1=MEM).
- **Grant rule, evaluated each cycle on the FIFO heads:**
  - Only one FIFO is non-empty: that source is granted.
  - Both FIFOs are non-empty: the source other than `last_grant` is granted.
  - Neither FIFO is non-empty: no grant, and `last_grant` is unchanged.
- **On a grant:**
  - The head entry is popped.
  - `wb_bus` <= {1'b1, head value, head addr}.
  - `last_grant` <= granted source.
- **No grant:** `wb_bus[68]` <= 0. `wb_bus[67:0]` holds its previous value.
- **Same-cycle push and pop:** allowed on the same FIFO. Occupancy is unchanged.
- **No combinational bypass:** an entry pushed at edge N is never granted before edge N+1.
- **Pointers and counts:**
  - Read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - The occupancy count is log2(DEPTH)+1 bits.
  - full = (count == DEPTH). empty = (count == 0).
- **Same destination in both FIFOs:** no coalescing. Both writes are issued in grant order.
  - Upstream must not have writes to the same destination outstanding in both sources.
- **Reset (asserted at any time, including mid-burst):**
  - All queued entries are discarded.
  - Counts and pointers go to 0.
  - `last_grant` goes to 1, so ALU wins the first tie.
  - `wb_bus` goes to 0 immediately, without waiting for a clock edge.
  - `alu_ready`=`mem_ready`=1 and `idle`=1.

## Timing
- **Latency:** request accepted at edge N into an empty FIFO with no contention → `wb_bus[68]`=1 after edge N+1. The register file commits the write at edge N+2.
- **Throughput:**
  - One write per cycle in aggregate.
  - Each source gets at least 1 grant in every 2 cycles while both FIFOs are backlogged.
- **Ready:** `x_ready` is a function of registered state only. There is no combinational path from `x_valid` to `x_ready`.
- **Pulse width:** `wb_bus[68]` is high for exactly one cycle per granted entry. Back-to-back grants keep it high continuously.
- **Idle:** `idle` is combinational from registered state.

## Configuration
- **Macro:** `WB_ARB_PENDING_MASK_EN`.
- **Defined:**
  - `pending_mask[r]`=1 iff register r is the destination of any valid entry in either FIFO, or of `wb_bus` while `wb_bus[68]`=1.
  - The mask is combinational from registered state and is used by the hazard/stall logic.
  - Reset value is 16'h0000.
- **Undefined:** the `pending_mask` port and its logic are absent. All other behaviour is identical.

## Test plan
- **Reset:** assert `reset` mid-cycle → `wb_bus`=69'h0 immediately, `alu_ready`=`mem_ready`=1, `idle`=1.
- **Single write:** ALU push addr 6, value 50 at edge N → `wb_bus`={1, 64'd50, 4'd6} after edge N+1. `wb_bus[68]`=0 after edge N+2 and `idle`=1.
- **Simultaneous pushes:** ALU (addr 3, 25) and MEM (addr 5, 7) at the same edge after reset → ALU entry issued first, MEM entry next cycle.
- **Continuous dual push, DEPTH=4:** both sources push every cycle for 10 cycles with incrementing values →
  - Grants alternate ALU/MEM.
  - Each `x_ready` falls once its FIFO reaches 4.
  - No entry is lost or duplicated, and per-source order is preserved.
  - Wrap-around is exercised.
- **Reset mid-burst:** assert `reset` with 3 entries queued in each FIFO → no further `wb_bus[68]` pulses after reset release until new pushes arrive.
- **Pending mask (`WB_ARB_PENDING_MASK_EN` defined):** ALU push addr 2, then MEM push addr 9 →
  - `pending_mask`=16'h0204 while both are outstanding.
  - Bit 2 clears the cycle after the ALU entry leaves `wb_bus`.
  - Mask reaches 16'h0000 once both writes have issued.

Source files
------------

// File: rtl/writeback_arbiter.sv
// Two-source writeback arbiter: per-source FIFOs, round-robin pop, registered 69-bit write-back bus.
// Optional WB_ARB_PENDING_MASK_EN adds a pending-destination mask output for hazard/stall logic.
module writeback_arbiter #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        alu_valid,
  output logic        alu_ready,
  input  logic [3:0]  alu_addr,
  input  logic [63:0] alu_value,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [3:0]  mem_addr,
  input  logic [63:0] mem_value,
  output logic [68:0] wb_bus,
`ifdef WB_ARB_PENDING_MASK_EN
  output logic [15:0] pending_mask,
`endif
  output logic        idle
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = 68;

  // Index 0 is the ALU source, index 1 the memory/load source.
  logic [1:0]         w_in_valid;
  logic [1:0][EW-1:0] w_in_data;
  logic [1:0][EW-1:0] w_head;
  logic [1:0]         w_ready;
  logic [1:0]         w_nempty;
  logic [1:0]         w_push;
  logic [1:0]         w_pop;
  logic               w_grant_any;
  logic               w_grant_src;
  logic               r_last_grant;
  logic [68:0]        r_wb_bus;
`ifdef WB_ARB_PENDING_MASK_EN
  logic [1:0][15:0]   w_fifo_mask;
`endif

  assign w_in_valid   = {mem_valid, alu_valid};
  assign w_in_data[0] = {alu_value, alu_addr};
  assign w_in_data[1] = {mem_value, mem_addr};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fifo
      logic [EW-1:0] r_mem [DEPTH];
      logic [AW-1:0] r_wr_ptr;
      logic [AW-1:0] r_rd_ptr;
      logic [CW-1:0] r_count;

      // A full FIFO refuses pushes even when it is popped in the same cycle.
      assign w_ready[gi]  = (r_count != CW'(DEPTH));
      assign w_nempty[gi] = (r_count != '0);
      assign w_push[gi]   = w_in_valid[gi] & w_ready[gi];
      assign w_pop[gi]    = w_grant_any & (w_grant_src == 1'(gi));
      assign w_head[gi]   = r_mem[r_rd_ptr];

      always_ff @(posedge clk) begin
        if (w_push[gi]) begin
          r_mem[r_wr_ptr] <= w_in_data[gi];
        end
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_wr_ptr <= '0;
          r_rd_ptr <= '0;
          r_count  <= '0;
        end else begin
          if (w_push[gi]) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
          end
          if (w_pop[gi]) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
          end
          r_count <= r_count + CW'(w_push[gi]) - CW'(w_pop[gi]);
        end
      end

`ifdef WB_ARB_PENDING_MASK_EN
      always_comb begin
        w_fifo_mask[gi] = '0;
        for (int i = 0; i < DEPTH; i++) begin
          if (CW'(i) < r_count) begin
            w_fifo_mask[gi][r_mem[r_rd_ptr + AW'(i)][3:0]] = 1'b1;
          end
        end
      end
`endif
    end
  endgenerate

  // On contention the source that did not win last time goes next.
  always_comb begin
    w_grant_any = |w_nempty;
    w_grant_src = 1'b0;
    if (&w_nempty) begin
      w_grant_src = ~r_last_grant;
    end else if (w_nempty[1]) begin
      w_grant_src = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last_grant <= 1'b1;
      r_wb_bus     <= '0;
    end else if (w_grant_any) begin
      r_last_grant <= w_grant_src;
      r_wb_bus     <= {1'b1, w_head[w_grant_src]};
    end else begin
      r_wb_bus[68] <= 1'b0;
    end
  end

  assign wb_bus    = r_wb_bus;
  assign alu_ready = w_ready[0];
  assign mem_ready = w_ready[1];
  assign idle      = ~(|w_nempty) & ~r_wb_bus[68];

`ifdef WB_ARB_PENDING_MASK_EN
  assign pending_mask = w_fifo_mask[0] | w_fifo_mask[1] |
                        (r_wb_bus[68] ? (16'h0001 << r_wb_bus[3:0]) : 16'h0000);
`endif

endmodule

// File: tb/tb_writeback_arbiter.sv
// Scoreboard bench for writeback_arbiter: a queue-based arbiter model predicts every bus write.
module tb_writeback_arbiter;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        alu_valid = 1'b0, mem_valid = 1'b0;
  logic        alu_ready, mem_ready;
  logic [3:0]  alu_addr = '0, mem_addr = '0;
  logic [63:0] alu_value = '0, mem_value = '0;
  logic [68:0] wb_bus;
  logic        idle;
`ifdef WB_ARB_PENDING_MASK_EN
  logic [15:0] pending_mask;
`endif

  int n_checks = 0;
  int n_errors = 0;

  logic [67:0] mq_a[$];
  logic [67:0] mq_m[$];
  logic [68:0] exp_q[$];
  logic        m_last = 1'b1;

  writeback_arbiter #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_value(alu_value),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_value(mem_value),
    .wb_bus(wb_bus),
`ifdef WB_ARB_PENDING_MASK_EN
    .pending_mask(pending_mask),
`endif
    .idle(idle)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [68:0] got, input logic [68:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called about 1 time unit after a rising edge; asserts reset mid-cycle.
  task automatic do_reset();
    #3;
    reset = 1'b1;
    #1;
    check("rst_bus", wb_bus, 69'h0);
    check("rst_alu_ready", {68'h0, alu_ready}, 69'h1);
    check("rst_mem_ready", {68'h0, mem_ready}, 69'h1);
    check("rst_idle", {68'h0, idle}, 69'h1);
`ifdef WB_ARB_PENDING_MASK_EN
    check("rst_mask", {53'h0, pending_mask}, 69'h0);
`endif
    mq_a.delete();
    mq_m.delete();
    exp_q.delete();
    m_last = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic step(input logic av, input logic [3:0] aa, input logic [63:0] ad,
                      input logic mv, input logic [3:0] ma, input logic [63:0] md);
    logic acc_a, acc_m, pulse, g;
    logic exp_ready_a, exp_ready_m, exp_idle;
    alu_valid = av; alu_addr = aa; alu_value = ad;
    mem_valid = mv; mem_addr = ma; mem_value = md;
    exp_ready_a = (mq_a.size() < DEPTH);
    exp_ready_m = (mq_m.size() < DEPTH);
    check("alu_ready", {68'h0, alu_ready}, {68'h0, exp_ready_a});
    check("mem_ready", {68'h0, mem_ready}, {68'h0, exp_ready_m});
    acc_a = av && exp_ready_a;
    acc_m = mv && exp_ready_m;
    pulse = 1'b0;
    g = 1'b0;
    if (mq_a.size() > 0 && mq_m.size() > 0) g = ~m_last;
    else if (mq_m.size() > 0) g = 1'b1;
    if (mq_a.size() > 0 || mq_m.size() > 0) begin
      pulse = 1'b1;
      m_last = g;
      if (g) exp_q.push_back({1'b1, mq_m.pop_front()});
      else   exp_q.push_back({1'b1, mq_a.pop_front()});
    end
    if (acc_a) mq_a.push_back({ad, aa});
    if (acc_m) mq_m.push_back({md, ma});
    @(posedge clk);
    #1;
    alu_valid = 1'b0;
    mem_valid = 1'b0;
    if (wb_bus[68]) begin
      $display("txn t=%0t addr=%0d value=%0d", $time, wb_bus[3:0], wb_bus[67:4]);
      if (exp_q.size() == 0) check("unexpected_write", wb_bus, 69'h0);
      else check("wb_bus", wb_bus, exp_q.pop_front());
    end else if (exp_q.size() != 0) begin
      check("wb_is_write", {68'h0, wb_bus[68]}, 69'h1);
      void'(exp_q.pop_front());
    end
    exp_idle = (mq_a.size() == 0) && (mq_m.size() == 0) && !pulse;
    check("idle", {68'h0, idle}, {68'h0, exp_idle});
  endtask

  task automatic idle_step();
    step(1'b0, 4'h0, 64'h0, 1'b0, 4'h0, 64'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset before any clock edge: bus must clear without waiting for clk.
    do_reset();

    // Single write: visible after the following edge, then the bus pulse ends.
    step(1'b1, 4'd6, 64'd50, 1'b0, 4'd0, 64'd0);
    check("single_no_bypass", {68'h0, wb_bus[68]}, 69'h0);
    idle_step();
    check("single_bus", wb_bus, {1'b1, 64'd50, 4'd6});
    idle_step();
    check("single_done", {67'h0, wb_bus[68], idle}, 69'h1);

    // Simultaneous pushes after reset: ALU wins the first tie.
    do_reset();
    step(1'b1, 4'd3, 64'd25, 1'b1, 4'd5, 64'd7);
    idle_step();
    check("sim_first", wb_bus, {1'b1, 64'd25, 4'd3});
    idle_step();
    check("sim_second", wb_bus, {1'b1, 64'd7, 4'd5});
    idle_step();

    // Continuous dual push: fills both FIFOs, wraps pointers, alternates grants.
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 4'(i), 64'(100 + i), 1'b1, 4'(i + 8), 64'(200 + i));
    end
    for (int i = 0; i < 12; i++) idle_step();
    check("burst_drained", {68'h0, idle}, 69'h1);

    // Reset mid-burst with three entries queued per source.
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 4'(i + 1), 64'(300 + i), 1'b1, 4'(i + 10), 64'(400 + i));
    end
    do_reset();
    for (int i = 0; i < 6; i++) idle_step();
    step(1'b0, 4'd0, 64'd0, 1'b1, 4'd12, 64'd77);
    idle_step();
    check("post_reset_write", wb_bus, {1'b1, 64'd77, 4'd12});
    idle_step();

`ifdef WB_ARB_PENDING_MASK_EN
    do_reset();
    step(1'b1, 4'd2, 64'd11, 1'b0, 4'd0, 64'd0);
    check("mask_alu", {53'h0, pending_mask}, {53'h0, 16'h0004});
    step(1'b0, 4'd0, 64'd0, 1'b1, 4'd9, 64'd22);
    check("mask_both", {53'h0, pending_mask}, {53'h0, 16'h0204});
    idle_step();
    check("mask_mem", {53'h0, pending_mask}, {53'h0, 16'h0200});
    idle_step();
    check("mask_clear", {53'h0, pending_mask}, 69'h0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
